// File: rtl/mem_b_writer.sv
// rtl/mem_b_writer.sv - Memory B writer: pairs source words and writes their absolute difference
//
// Purpose:
//   Consumes the Memory A word stream over a valid/ready handshake, groups
//   consecutive words into pairs and, for every pair, issues one Memory B
//   write of |first - second| at an internally counted address. A run covers
//   every Memory B address once (2^ADDR_W writes) and ends with a Done pulse.
//
// Ports:
//   clk       in   system clock, rising edge
//   Reset     in   synchronous active-low reset
//   Start     in   begin a run (honoured only while idle)
//   DataIn    in   [DATA_W] source word
//   InValid   in   DataIn valid
//   InReady   out  writer accepts DataIn
//   WEB       out  Memory B write enable, one-cycle pulse per write
//   AddrB     out  [ADDR_W] Memory B write address
//   DataOutB  out  [DATA_W] Memory B write data
//   Busy      out  run in progress (state other than IDLE)
//   Done      out  one-cycle pulse at run completion
//   Checksum  out  [DATA_W] modulo-2^DATA_W sum of the run's writes
//                  (present only with MEM_B_WRITER_CHECKSUM_EN defined)
//
// Optional feature macro: MEM_B_WRITER_CHECKSUM_EN

module mem_b_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              InValid,
    output logic              InReady,
    output logic              WEB,
    output logic [ADDR_W-1:0] AddrB,
    output logic [DATA_W-1:0] DataOutB,
    output logic              Busy,
`ifdef MEM_B_WRITER_CHECKSUM_EN
    output logic [DATA_W-1:0] Checksum,
`endif
    output logic              Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_FIRST,
        S_GET_SECOND,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] first_q;
    logic [DATA_W-1:0] second_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] abs_diff;
    logic              last_addr;

    // Both operands are registered, so the write data has no path from the
    // inputs. The larger operand is always the minuend, so no overflow.
    assign abs_diff  = (first_q >= second_q) ? (first_q - second_q)
                                             : (second_q - first_q);
    assign last_addr = (AddrB == {ADDR_W{1'b1}});

    // Control outputs decode the registered state only.
    assign InReady = (state == S_GET_FIRST) || (state == S_GET_SECOND);
    assign WEB     = (state == S_WRITE);
    assign Busy    = (state != S_IDLE);
    assign Done    = (state == S_DONE);

    // During WRITE the fresh difference is presented; afterwards out_q keeps
    // it stable so DataOutB holds its last written value while the next
    // pair is being collected into first_q/second_q.
    assign DataOutB = (state == S_WRITE) ? abs_diff : out_q;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state    <= S_IDLE;
            first_q  <= '0;
            second_q <= '0;
            out_q    <= '0;
            AddrB    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        AddrB <= '0;
                        state <= S_GET_FIRST;
                    end
                end
                S_GET_FIRST: begin
                    if (InValid) begin
                        first_q <= DataIn;
                        state   <= S_GET_SECOND;
                    end
                end
                S_GET_SECOND: begin
                    if (InValid) begin
                        second_q <= DataIn;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    out_q <= abs_diff;
                    if (last_addr) begin
                        state <= S_DONE;
                    end else begin
                        AddrB <= AddrB + 1'b1;
                        state <= S_GET_FIRST;
                    end
                end
                S_DONE: begin
                    // Start is deliberately not examined here.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_B_WRITER_CHECKSUM_EN
    // Accumulates on the WRITE edge, so the sum reflects a write in the
    // cycle after its WEB pulse and is final by the DONE cycle.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            Checksum <= '0;
        end else if (state == S_IDLE && Start) begin
            Checksum <= '0;
        end else if (state == S_WRITE) begin
            Checksum <= Checksum + abs_diff;
        end
    end
`endif

endmodule
